i2c_rtc_reader: RTL and testbench
=================================

I2C_RTC_READER -- requirements
Module: i2c_rtc_reader

Interface
REQ-001 Parameter: CLK_DIV, default 250, system clocks per SCL quarter-period (100 kHz at 100 MHz); legal range 2..1023.
REQ-002 Parameter: DEV_ADDR, default 7'h68, 7-bit I2C address of the RTC device.
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  single-cycle request to read one RTC register.
REQ-006 Port: reg_addr  input  8  RTC register pointer, sampled on an accepted start.
REQ-007 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-008 Port: done  output  1  one-cycle pulse at the end of a transaction, success or error.
REQ-009 Port: ack_error  output  1  valid with done; 1 if any slave ACK was missing.
REQ-010 Port: i2c_data_out  output  8  byte read from the RTC (raw BCD); drives the BCD-to-binary converter's i2c_data_in.
REQ-011 Port: scl  output  1  I2C clock, open-drain style; 1 = released.
REQ-012 Port: sda_oe  output  1  1 = drive SDA low, 0 = release SDA.
REQ-013 Port: sda_in  input  1  sampled SDA line, already synchronised by the pad wrapper.

Function
REQ-014 Transaction SHALL be: START, DEV_ADDR+W, ACK, reg_addr, ACK, repeated START, DEV_ADDR+R, ACK, read 8 bits MSB first, master NACK, STOP.
REQ-015 FSM states SHALL be IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, FINISH; TX_BYTE/RX_ACK are reused for the three transmitted bytes, selected by a byte index 0..2.
REQ-016 Each bit SHALL occupy 4 quarter-phases of CLK_DIV clocks: SCL low in phases 0-1 and high in phases 2-3; SDA changes only at the start of phase 0; sda_in is sampled on the last clock of phase 2.
REQ-017 START/RESTART: SDA falls while SCL is high; STOP: SDA rises while SCL is high; each condition lasts one full bit period.
REQ-018 start SHALL be accepted only in IDLE; start while busy is ignored with no side effect.
REQ-019 An ACK sampled high SHALL set ack_error, abort the remaining bytes, and go directly to STOP; i2c_data_out is left unchanged.
REQ-020 On success, i2c_data_out SHALL update in the same cycle that done pulses and hold until the next successful read.
REQ-021 done SHALL assert exactly one cycle after STOP completes (FINISH state); busy falls in the same cycle; FSM returns to IDLE on the next cycle.
REQ-022 ack_error SHALL be cleared when a new start is accepted.
REQ-023 Total transaction length SHALL be exactly 39 bit periods (156*CLK_DIV clocks) from the first START phase to the end of STOP on success.
REQ-024 In IDLE, scl=1 and sda_oe=0.

Reset
REQ-025 rst asserted at any time, including mid-byte, SHALL asynchronously force IDLE with scl=1, sda_oe=0, busy=0, done=0, ack_error=0, i2c_data_out=8'h00, and all counters zeroed.
REQ-026 After rst deasserts, a start is accepted no earlier than the first rising clk edge.

Structure
REQ-027 The shared package SHALL hold the FSM state enumeration, the default RTC address 7'h68, and RTC register constants (seconds 8'h00, minutes 8'h01, hours 8'h02).
REQ-028 One sub-module, i2c_phase_gen, SHALL be used: a CLK_DIV counter producing a quarter-phase tick and a 2-bit phase index; it is held in reset while the FSM is in IDLE.

Verification
REQ-029 CLK_DIV=4, slave model ACKs all bytes and returns 8'h59 for reg 8'h00 -> observed SCL bytes are 8'hD0, 8'h00, 8'hD1; i2c_data_out=8'h59, done pulses once, ack_error=0, 624 clocks total.
REQ-030 Slave model NACKs the address byte -> ack_error=1 with done; STOP follows the first ACK slot; i2c_data_out keeps its previous value.
REQ-031 Slave model NACKs reg_addr 8'h02 -> no repeated START occurs, STOP is issued, ack_error=1.
REQ-032 A second start pulse 100 clocks into a transfer -> ignored; exactly one done is produced.
REQ-033 rst asserted during the RX_BYTE phase -> scl=1, sda_oe=0, busy=0 immediately (without waiting for a clock); a following read of 8'h23 completes normally.
REQ-034 Back-to-back reads of regs 8'h00, 8'h01, 8'h02 returning 8'h45, 8'h30, 8'h12 -> i2c_data_out takes each value in turn, exactly at each done pulse.

Source files
------------

// File: rtl/i2c_rtc_reader_pkg.sv
// i2c_rtc_reader_pkg: FSM encoding, RTC constants and the per-state bus drive decode
package i2c_rtc_reader_pkg;
    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, FINISH
    } state_t;

    localparam logic [6:0] RTC_ADDR    = 7'h68;
    localparam logic [7:0] REG_SECONDS = 8'h00;
    localparam logic [7:0] REG_MINUTES = 8'h01;
    localparam logic [7:0] REG_HOURS   = 8'h02;

    // Returns {scl, sda_oe}; START/RESTART pull SDA low in phases 2-3 with SCL high,
    // STOP releases SDA in phase 2 with SCL high.
    function automatic logic [1:0] bus_drive(state_t s, logic [1:0] ph, logic tx_bit);
        return s == START   ? {1'b1, ph[1]} :
               s == RESTART ? {ph != 2'd0, ph[1]} :
               s == STOP    ? {ph != 2'd0, ~ph[1]} :
               s == TX_BYTE ? {ph[1], ~tx_bit} :
               s inside {RX_ACK, RX_BYTE, TX_NACK} ? {ph[1], 1'b0} : 2'b10;
    endfunction
endpackage

// File: rtl/i2c_rtc_reader_phase_gen.sv
// i2c_phase_gen: divides clk into SCL quarter-phase ticks and a 2-bit phase index
module i2c_phase_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output logic       tick,
    output logic [1:0] phase
);
    logic [9:0] cnt;

    assign tick = cnt == 10'(CLK_DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= '0;
        end else if (hold) begin
            cnt   <= '0;
            phase <= '0;
        end else begin
            cnt   <= tick ? '0 : cnt + 10'd1;
            phase <= phase + 2'(tick);
        end
    end
endmodule

// File: rtl/i2c_rtc_reader.sv
// i2c_rtc_reader: I2C master that reads one RTC register with a write-pointer / repeated-start read
module i2c_rtc_reader
    import i2c_rtc_reader_pkg::*;
#(
    parameter int         CLK_DIV  = 250,
    parameter logic [6:0] DEV_ADDR = RTC_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] reg_addr,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [7:0] i2c_data_out,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);
    state_t     state;
    logic       tick, bit_end, sample, ack_bit;
    logic [1:0] phase, byte_idx, drive;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh, rx_sh, addr_q;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .hold  (state == IDLE),
        .tick  (tick),
        .phase (phase)
    );

    assign bit_end = tick && phase == 2'd3;
    assign sample  = tick && phase == 2'd2;
    assign drive   = bus_drive(state, phase, tx_sh[7]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            scl          <= 1'b1;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ack_error    <= 1'b0;
            ack_bit      <= 1'b0;
            i2c_data_out <= '0;
            byte_idx     <= '0;
            bit_cnt      <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            addr_q       <= '0;
        end else begin
            {scl, sda_oe} <= drive;
            done          <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= START;
                    busy      <= 1'b1;
                    ack_error <= 1'b0;
                    addr_q    <= reg_addr;
                    byte_idx  <= '0;
                    bit_cnt   <= '0;
                end
                START: if (bit_end) begin
                    tx_sh <= {DEV_ADDR, 1'b0};
                    state <= TX_BYTE;
                end
                TX_BYTE: if (bit_end) begin
                    tx_sh   <= tx_sh << 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= RX_ACK;
                end
                RX_ACK: begin
                    if (sample) ack_bit <= sda_in;
                    // A missing ACK skips every remaining byte and goes straight to STOP.
                    if (bit_end) begin
                        if (ack_bit) begin
                            ack_error <= 1'b1;
                            state     <= STOP;
                        end else if (byte_idx == 2'd0) begin
                            tx_sh    <= addr_q;
                            byte_idx <= 2'd1;
                            state    <= TX_BYTE;
                        end else if (byte_idx == 2'd1) begin
                            byte_idx <= 2'd2;
                            state    <= RESTART;
                        end else begin
                            state <= RX_BYTE;
                        end
                    end
                end
                RESTART: if (bit_end) begin
                    tx_sh <= {DEV_ADDR, 1'b1};
                    state <= TX_BYTE;
                end
                RX_BYTE: begin
                    if (sample) rx_sh <= {rx_sh[6:0], sda_in};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= TX_NACK;
                    end
                end
                TX_NACK: if (bit_end) state <= STOP;
                STOP: if (bit_end) begin
                    state <= FINISH;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (!ack_error) i2c_data_out <= rx_sh;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_rtc_reader.sv
// tb_i2c_rtc_reader: directed tests against an I2C RTC slave model on an open-drain SDA line
module tb_i2c_rtc_reader;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] reg_addr;
    logic       busy, done, ack_error, scl, sda_oe, sda_in;
    logic [7:0] i2c_data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2c_rtc_reader #(.CLK_DIV(4), .DEV_ADDR(7'h68)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .reg_addr     (reg_addr),
        .busy         (busy),
        .done         (done),
        .ack_error    (ack_error),
        .i2c_data_out (i2c_data_out),
        .scl          (scl),
        .sda_oe       (sda_oe),
        .sda_in       (sda_in)
    );

    // Slave model: bit index b counts SCL rises within a byte, fb is the byte within a frame.
    logic [7:0] mem [0:255];
    logic       nack_addr = 1'b0, nack_reg = 1'b0;
    logic       slv_low = 1'b0, p_scl = 1'b1, p_sda = 1'b1, rd = 1'b0, m_ack = 1'b0;
    logic [3:0] b = '0;
    logic [1:0] fb = '0;
    logic [7:0] sh = '0, ptr = '0;
    logic [7:0] obs [0:63];
    int         n_obs = 0, n_start = 0, n_stop = 0;
    logic       sda_line;

    assign sda_line = !sda_oe && !slv_low;
    assign sda_in   = sda_line;

    always @(posedge clk) begin
        p_scl <= scl;
        p_sda <= sda_line;
        if (rst) begin
            slv_low <= 1'b0;
            b       <= '0;
            p_scl   <= 1'b1;
            p_sda   <= 1'b1;
        end else if (p_scl && scl && p_sda && !sda_line) begin
            n_start <= n_start + 1;
            b       <= '0;
            fb      <= '0;
            rd      <= 1'b0;
            slv_low <= 1'b0;
        end else if (p_scl && scl && !p_sda && sda_line) begin
            n_stop  <= n_stop + 1;
            b       <= '0;
            slv_low <= 1'b0;
        end else if (!p_scl && scl) begin
            sh <= {sh[6:0], sda_line};
            b  <= b + 4'd1;
            if (b == 4'd7) begin
                obs[n_obs] <= {sh[6:0], sda_line};
                n_obs      <= n_obs + 1;
                if (fb == 2'd0) rd <= sda_line;
                if (fb == 2'd1 && !rd) ptr <= {sh[6:0], sda_line};
            end
            if (b == 4'd8 && rd && fb == 2'd1) m_ack <= sda_line;
        end else if (p_scl && !scl) begin
            if (b == 4'd8)
                slv_low <= (rd && fb == 2'd1) ? 1'b0 : !((fb == 2'd0 && nack_addr) || (fb == 2'd1 && nack_reg));
            else if (b == 4'd9) begin
                b       <= '0;
                fb      <= fb + 2'd1;
                slv_low <= rd && fb == 2'd0 && !mem[ptr][7];
            end else if (rd && fb == 2'd1 && b >= 4'd1 && b <= 4'd7)
                slv_low <= !mem[ptr][3'(7 - int'(b))];
            else
                slv_low <= 1'b0;
        end
    end

    int         busy_cyc, extra_done, base_obs, base_start, base_stop;
    logic       got_done, ack_first;
    logic [7:0] pre_done;

    // Issues one read and waits (bounded) for done; optionally pulses a second start mid-transfer.
    task automatic read_reg(input logic [7:0] a, input int second_at);
        int n;
        busy_cyc   = 0;
        extra_done = 0;
        base_obs   = n_obs;
        base_start = n_start;
        base_stop  = n_stop;
        @(negedge clk);
        start    = 1'b1;
        reg_addr = a;
        @(negedge clk);
        start     = 1'b0;
        ack_first = ack_error;
        n = 0;
        while (!done && n < 4000) begin
            if (busy) busy_cyc++;
            pre_done = i2c_data_out;
            start    = (n == second_at);
            if (n == second_at) reg_addr = 8'h02;
            @(negedge clk);
            n++;
        end
        start    = 1'b0;
        got_done = done;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL done_timeout reg=%h: no done within %0d cycles", a, n);
        end
    endtask

    task automatic count_trailing_done();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; reg_addr = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (scl !== 1'b1)            begin errors++; $display("FAIL reset_scl got %b want 1", scl); end
        if (sda_oe !== 1'b0)         begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)           begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (ack_error !== 1'b0)      begin errors++; $display("FAIL reset_ack_error got %b want 0", ack_error); end
        if (i2c_data_out !== 8'h00)  begin errors++; $display("FAIL reset_data got %h want 00", i2c_data_out); end
    endtask

    task automatic test_read_seconds();
        logic [7:0] exp_bytes [0:3];
        exp_bytes[0] = 8'hD0; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hD1; exp_bytes[3] = 8'h59;
        mem[8'h00] = 8'h59;
        read_reg(8'h00, -1);
        count_trailing_done();
        checks += 7;
        if (i2c_data_out !== 8'h59)   begin errors++; $display("FAIL rd_data got %h want 59", i2c_data_out); end
        if (ack_error !== 1'b0)       begin errors++; $display("FAIL rd_ack_error got %b want 0", ack_error); end
        if (busy_cyc != 624)          begin errors++; $display("FAIL rd_length got %0d want 624", busy_cyc); end
        if (extra_done != 0)          begin errors++; $display("FAIL rd_done_once extra=%0d want 0", extra_done); end
        if (n_start - base_start != 2) begin errors++; $display("FAIL rd_starts got %0d want 2", n_start - base_start); end
        if (n_stop - base_stop != 1)  begin errors++; $display("FAIL rd_stops got %0d want 1", n_stop - base_stop); end
        if (m_ack !== 1'b1)           begin errors++; $display("FAIL rd_master_nack got %b want 1", m_ack); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[base_obs + k] !== exp_bytes[k]) begin
                errors++;
                $display("FAIL rd_byte%0d got %h want %h", k, obs[base_obs + k], exp_bytes[k]);
            end
        end
    endtask

    task automatic test_addr_nack();
        nack_addr = 1'b1;
        read_reg(8'h00, -1);
        nack_addr = 1'b0;
        checks += 5;
        if (ack_error !== 1'b1)        begin errors++; $display("FAIL an_ack_error got %b want 1", ack_error); end
        if (i2c_data_out !== 8'h59)    begin errors++; $display("FAIL an_data_kept got %h want 59", i2c_data_out); end
        if (n_obs - base_obs != 1)     begin errors++; $display("FAIL an_bytes got %0d want 1", n_obs - base_obs); end
        if (n_stop - base_stop != 1)   begin errors++; $display("FAIL an_stops got %0d want 1", n_stop - base_stop); end
        if (busy_cyc != 176)           begin errors++; $display("FAIL an_length got %0d want 176", busy_cyc); end
    endtask

    task automatic test_reg_nack();
        nack_reg = 1'b1;
        read_reg(8'h02, -1);
        nack_reg = 1'b0;
        checks += 5;
        if (ack_error !== 1'b1)         begin errors++; $display("FAIL rn_ack_error got %b want 1", ack_error); end
        if (n_start - base_start != 1)  begin errors++; $display("FAIL rn_no_restart starts=%0d want 1", n_start - base_start); end
        if (n_stop - base_stop != 1)    begin errors++; $display("FAIL rn_stops got %0d want 1", n_stop - base_stop); end
        if (obs[base_obs + 1] !== 8'h02) begin errors++; $display("FAIL rn_reg_byte got %h want 02", obs[base_obs + 1]); end
        if (i2c_data_out !== 8'h59)     begin errors++; $display("FAIL rn_data_kept got %h want 59", i2c_data_out); end
    endtask

    task automatic test_ignored_start();
        mem[8'h01] = 8'h37;
        mem[8'h02] = 8'hAA;
        read_reg(8'h01, 100);
        count_trailing_done();
        checks += 6;
        if (ack_first !== 1'b0)          begin errors++; $display("FAIL is_ack_cleared got %b want 0", ack_first); end
        if (i2c_data_out !== 8'h37)      begin errors++; $display("FAIL is_data got %h want 37", i2c_data_out); end
        if (obs[base_obs + 1] !== 8'h01) begin errors++; $display("FAIL is_reg_byte got %h want 01", obs[base_obs + 1]); end
        if (busy_cyc != 624)             begin errors++; $display("FAIL is_length got %0d want 624", busy_cyc); end
        if (extra_done != 0)             begin errors++; $display("FAIL is_done_once extra=%0d want 0", extra_done); end
        if (ack_error !== 1'b0)          begin errors++; $display("FAIL is_ack_error got %b want 0", ack_error); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        start    = 1'b1;
        reg_addr = 8'h00;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 480 && busy) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (scl !== 1'b1)           begin errors++; $display("FAIL rm_scl got %b want 1", scl); end
        if (sda_oe !== 1'b0)        begin errors++; $display("FAIL rm_sda_oe got %b want 0", sda_oe); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
        if (i2c_data_out !== 8'h00) begin errors++; $display("FAIL rm_data got %h want 00", i2c_data_out); end
        if (n != 480)               begin errors++; $display("FAIL rm_reached_rx busy_cycles=%0d want 480", n); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem[8'h00] = 8'h23;
        read_reg(8'h00, -1);
        checks += 3;
        if (i2c_data_out !== 8'h23) begin errors++; $display("FAIL rm_after_data got %h want 23", i2c_data_out); end
        if (ack_error !== 1'b0)     begin errors++; $display("FAIL rm_after_ack got %b want 0", ack_error); end
        if (busy_cyc != 624)        begin errors++; $display("FAIL rm_after_length got %0d want 624", busy_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [0:2];
        logic [7:0] prev;
        vals[0] = 8'h45; vals[1] = 8'h30; vals[2] = 8'h12;
        for (int r = 0; r < 3; r++) mem[r] = vals[r];
        prev = 8'h23;
        for (int r = 0; r < 3; r++) begin
            read_reg(8'(r), -1);
            checks += 2;
            if (pre_done !== prev) begin
                errors++; $display("FAIL b2b_hold%0d got %h want %h", r, pre_done, prev);
            end
            if (i2c_data_out !== vals[r]) begin
                errors++; $display("FAIL b2b_data%0d got %h want %h", r, i2c_data_out, vals[r]);
            end
            prev = vals[r];
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_read_seconds();
        test_addr_nack();
        test_reg_nack();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
